chebyshev_term_gen: RTL and testbench

Iterative Chebyshev term generator. On a start pulse it latches a fixed-point argument x and an order N, then emits T_0(x) … T_N(x) one term per accepted transfer using T_{k+1} = 2·x·T_k − T_{k−1}. Each term is tagged with its index k. It sits upstream of the coefficient/accumulate stage, which consumes the term stream with a valid/ready handshake.

---
 rtl/chebyshev_pkg.sv | 34 +++
 rtl/chebyshev_fx_step.sv | 35 +++
 rtl/chebyshev_term_gen.sv | 115 +++++++++++
 tb/tb_chebyshev_term_gen.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/chebyshev_pkg.sv
// Shared definitions for the Chebyshev term generator.
//   state_t        : FSM state encoding (IDLE, RUN)
//   *_DEF          : default DATA_WIDTH / FRAC_BITS / ORDER_WIDTH
//   ONE            : 1.0 in the default fixed-point format
//   sat_to_width() : clamp a signed value into a signed w-bit range
package chebyshev_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DATA_WIDTH_DEF  = 16;
    localparam int FRAC_BITS_DEF   = 14;
    localparam int ORDER_WIDTH_DEF = 6;

    localparam logic signed [DATA_WIDTH_DEF-1:0] ONE = DATA_WIDTH_DEF'(1) << FRAC_BITS_DEF;

    // Works on a 64-bit carrier so one function serves any width up to 63 bits.
    function automatic longint sat_to_width(input longint v, input int w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - longint'(1);
        lo = -(longint'(1) <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/chebyshev_fx_step.sv
// One step of the Chebyshev recurrence, purely combinational:
//   t_next = sat((x * t_cur) >>> (FRAC_BITS-1) - t_prev)
// Ports:
//   x, t_cur, t_prev : signed DATA_WIDTH operands, Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS
//   t_next           : saturated signed DATA_WIDTH result
module chebyshev_fx_step
    import chebyshev_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_BITS  = FRAC_BITS_DEF
) (
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] t_cur,
    input  logic signed [DATA_WIDTH-1:0] t_prev,
    output logic signed [DATA_WIDTH-1:0] t_next
);

    localparam int PW = 2 * DATA_WIDTH;

    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic signed [PW:0]   diff;

    // Shifting by FRAC_BITS-1 folds the factor of two into the rescale.
    assign prod   = x * t_cur;
    assign scaled = prod >>> (FRAC_BITS - 1);

    // The difference is kept at full product width plus one so that even the
    // (-1.0 * -1.0)-style corner cases reach the saturator without wrapping.
    assign diff = {scaled[PW-1], scaled}
                - {{(PW + 1 - DATA_WIDTH){t_prev[DATA_WIDTH-1]}}, t_prev};

    assign t_next = DATA_WIDTH'(sat_to_width(longint'(diff), DATA_WIDTH));

endmodule

// File: rtl/chebyshev_term_gen.sv
// Iterative Chebyshev term generator: after a start in IDLE it latches x and
// N, then streams T_0(x) .. T_N(x), one term per accepted transfer.
// Ports:
//   clock, resetn        : rising-edge clock, async active-low reset
//   start                : begin a sequence (sampled only in IDLE)
//   x_in, order_in       : argument x and highest index N
//   out_valid/out_ready  : output handshake
//   out_data/out_index   : current term T_k and its index k
//   out_last             : k == N
//   busy                 : a sequence is in progress
//   done                 : one-cycle pulse after the final transfer
//   fsm_state            : current FSM state, for observation
// Handshake: a term transfers on a rising edge where out_valid && out_ready.
// While out_valid && !out_ready every out_* signal holds and nothing advances.
module chebyshev_term_gen
    import chebyshev_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int FRAC_BITS   = FRAC_BITS_DEF,
    parameter int ORDER_WIDTH = ORDER_WIDTH_DEF
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          start,
    input  logic signed [DATA_WIDTH-1:0]  x_in,
    input  logic        [ORDER_WIDTH-1:0] order_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic        [ORDER_WIDTH-1:0] out_index,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output state_t                        fsm_state
);

    localparam logic signed [DATA_WIDTH-1:0] ONE_W = DATA_WIDTH'(1) << FRAC_BITS;

    state_t                       state;
    logic signed [DATA_WIDTH-1:0] x_reg;
    logic signed [DATA_WIDTH-1:0] t_cur;
    logic signed [DATA_WIDTH-1:0] t_prev;
    logic signed [DATA_WIDTH-1:0] t_step;
    logic signed [DATA_WIDTH-1:0] t_next;
    logic        [ORDER_WIDTH-1:0] k;
    logic        [ORDER_WIDTH-1:0] n_reg;
    logic                          last_reg;
    logic                          done_reg;

    chebyshev_fx_step #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_step (
        .x      (x_reg),
        .t_cur  (t_cur),
        .t_prev (t_prev),
        .t_next (t_step)
    );

    // T_1 = x exactly; the general recurrence would give 2x from (ONE, 0).
    assign t_next = (k == '0) ? x_reg : t_step;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            x_reg    <= '0;
            t_cur    <= '0;
            t_prev   <= '0;
            k        <= '0;
            n_reg    <= '0;
            last_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_reg    <= x_in;
                        n_reg    <= order_in;
                        t_cur    <= ONE_W;
                        t_prev   <= '0;
                        k        <= '0;
                        last_reg <= (order_in == '0);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        if (k == n_reg) begin
                            last_reg <= 1'b0;
                            done_reg <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            t_prev   <= t_cur;
                            t_cur    <= t_next;
                            k        <= k + 1'b1;
                            last_reg <= ((k + 1'b1) == n_reg);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Every output is a register or a decode of the state register only.
    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign out_data  = t_cur;
    assign out_index = k;
    assign out_last  = last_reg;
    assign done      = done_reg;
    assign fsm_state = state;

endmodule

// File: tb/tb_chebyshev_term_gen.sv
module tb_chebyshev_term_gen;
  import chebyshev_pkg::*;

  localparam int DW = 16;
  localparam int FB = 14;
  localparam int OW = 6;
  localparam int EW = DW + OW + 1;  // {last, index, data}

  logic                 clock;
  logic                 resetn;
  logic                 start;
  logic signed [DW-1:0] x_in;
  logic [OW-1:0]        order_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [OW-1:0]        out_index;
  logic                 out_last;
  logic                 busy;
  logic                 done;
  state_t               fsm_state;

  chebyshev_term_gen #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .ORDER_WIDTH(OW)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .x_in      (x_in),
    .order_in  (order_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- checking ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] exp_q[$];
  logic          exp_done = 1'b0;
  logic          mon_en   = 1'b0;

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // T_0 = 1, T_1 = x, T_{k+1} = sat(floor(2 x T_k) - T_{k-1}) in real-valued
  // terms, carried out on integers scaled by 2^FB.
  task automatic model_push(input longint x, input int n);
    longint scale;
    longint tp;
    longint tc;
    longint tn;
    longint p;
    longint q;
    scale = longint'(1) << FB;
    tp = 0;
    tc = scale;
    for (int k = 0; k <= n; k++) begin
      exp_q.push_back({(k == n), OW'(k), DW'(tc)});
      if (k == 0) begin
        tn = x;
      end else begin
        p = 2 * x * tc;
        q = p / scale;
        if ((p % scale != 0) && (p < 0)) q = q - 1;
        tn = clamp16(q - tp);
      end
      tp = tc;
      tc = tn;
    end
  endtask

  task automatic push_exp(input longint data, input int index, input bit last);
    exp_q.push_back({last, OW'(index), DW'(data)});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [EW-1:0] e;
    if (mon_en && resetn) begin
      check("done", done, exp_done);
      check("busy", busy, exp_q.size() != 0);
      check("out_valid", out_valid, exp_q.size() != 0);
      exp_done = 1'b0;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        check("out_data", longint'(out_data), longint'($signed(e[DW-1:0])));
        check("out_index", out_index, e[DW+OW-1:DW]);
        check("out_last", out_last, e[EW-1]);
        if (out_ready) begin
          void'(exp_q.pop_front());
          if (e[EW-1]) exp_done = 1'b1;
        end
      end
    end
  end

  // ---------------- out_ready driver ----------------
  int ready_mode  = 0;  // 0: always ready, 1: 1,0,0,1 pattern, 2: random
  int ready_phase = 0;
  bit ready_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      case (ready_mode)
        1: begin
          out_ready = ready_pat[ready_phase % 4];
          ready_phase++;
        end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a rising-edge time; start is sampled on the following edge.
  task automatic start_seq(input logic signed [DW-1:0] x, input int n, input bit use_model);
    #1;
    x_in     = x;
    order_in = OW'(n);
    start    = 1'b1;
    @(posedge clock);
    #1;
    start    = 1'b0;
    x_in     = DW'($urandom);
    order_in = OW'($urandom);
    if (use_model) model_push(longint'(x), n);
  endtask

  task automatic wait_idle(input int budget);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < budget) begin
      @(posedge clock);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      check("timeout_terms_left", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, longint'(out_data), 0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_last"}, out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    x_in     = '0;
    order_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check_outputs_zero("reset");
    resetn = 1'b1;
    mon_en = 1'b1;
    @(posedge clock);

    // x = 0.5, N = 4
    ready_mode = 0;
    start_seq(16'sd8192, 4, 1'b0);
    push_exp(16384, 0, 0); push_exp(8192, 1, 0); push_exp(-8192, 2, 0);
    push_exp(-16384, 3, 0); push_exp(-8192, 4, 1);
    wait_idle(50);
    repeat (2) @(posedge clock);

    // x = 0, N = 4
    start_seq(16'sd0, 4, 1'b0);
    push_exp(16384, 0, 0); push_exp(0, 1, 0); push_exp(-16384, 2, 0);
    push_exp(0, 3, 0); push_exp(16384, 4, 1);
    wait_idle(50);
    repeat (2) @(posedge clock);

    // x = 1.5, N = 3: saturation carried into the next term
    start_seq(16'sd24576, 3, 1'b0);
    push_exp(16384, 0, 0); push_exp(24576, 1, 0); push_exp(32767, 2, 0);
    push_exp(32767, 3, 1);
    wait_idle(50);
    repeat (2) @(posedge clock);

    // N = 0
    start_seq(16'sd5000, 0, 1'b0);
    push_exp(16384, 0, 1);
    wait_idle(50);
    repeat (2) @(posedge clock);

    // Stalls with a start pulse mid-sequence that must be ignored
    ready_mode  = 1;
    ready_phase = 0;
    start_seq(16'sd8192, 3, 1'b0);
    push_exp(16384, 0, 0); push_exp(8192, 1, 0); push_exp(-8192, 2, 0);
    push_exp(-16384, 3, 1);
    repeat (2) @(posedge clock);
    #1;
    start    = 1'b1;
    x_in     = 16'sd1234;
    order_in = 6'd9;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_idle(100);
    repeat (2) @(posedge clock);

    // Reset while index 2 is on the output
    ready_mode = 0;
    start_seq(16'sd8192, 4, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    check("pre_reset_index", out_index, 2);
    resetn = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    exp_done = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock);
    start_seq(16'sd0, 1, 1'b0);
    push_exp(16384, 0, 0); push_exp(0, 1, 1);
    wait_idle(50);
    repeat (2) @(posedge clock);

    // Randomized sequences against the model, some back-to-back
    for (int i = 0; i < 14; i++) begin
      int n;
      ready_mode = $urandom_range(0, 2);
      n = (i == 13) ? 40 : $urandom_range(0, 15);
      start_seq(DW'($urandom), n, 1'b1);
      wait_idle(2000);
      repeat ($urandom_range(0, 3)) @(posedge clock);
    end

    ready_mode = 0;
    repeat (4) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
